// File: rtl/timing_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// timing_sequencer_pkg
// Shared definitions for the timing sequencer slice.
//   - Named timing-state indices for the standard instruction phases.
//   - Default number of timing states.
//   - Per-edge priority enumeration, plus a helper that resolves the
//     request inputs into a single winning action.
// ---------------------------------------------------------------------------
package timing_sequencer_pkg;

  // Named timing-state indices for the standard instruction phases
  localparam int T_FETCH_L = 0;
  localparam int T_FETCH_H = 1;
  localparam int T_DECODE  = 2;
  localparam int T_EXEC0   = 3;

  // Default number of one-hot timing states
  localparam int DEFAULT_T_WIDTH = 8;

  // Action taken on a clock edge, listed from highest to lowest priority
  typedef enum logic [2:0] {
    PRI_RESET,
    PRI_CLEAR,
    PRI_LOAD,
    PRI_HOLD,
    PRI_INC
  } priority_e;

  // Collapse the request inputs into the single action that wins this edge.
  // Reset beats everything, then Clear, then Load, then Hold; when nothing
  // is requested the sequence simply advances.
  function automatic priority_e resolve_priority(input logic reset,
                                                 input logic clear,
                                                 input logic load,
                                                 input logic hold);
    priority_e pri;
    if (reset)      pri = PRI_RESET;
    else if (clear) pri = PRI_CLEAR;
    else if (load)  pri = PRI_LOAD;
    else if (hold)  pri = PRI_HOLD;
    else            pri = PRI_INC;
    return pri;
  endfunction

endpackage

// File: rtl/sc_onehot_decode.sv
// ---------------------------------------------------------------------------
// sc_onehot_decode
// Purely combinational decoder from the binary state index to the one-hot
// timing vector. Bit i of onehot is set when sc equals i. Index values at
// or beyond T_WIDTH decode to all zeros, but the sequencer never lets its
// state register reach such a value.
//
// Ports:
//   sc      input  [CNT_W-1:0]    binary state index
//   onehot  output [T_WIDTH-1:0]  one-hot timing vector
// ---------------------------------------------------------------------------
module sc_onehot_decode #(
  parameter int T_WIDTH = 8,
  parameter int CNT_W   = $clog2(T_WIDTH)
) (
  input  logic [CNT_W-1:0]   sc,
  output logic [T_WIDTH-1:0] onehot
);

  // Compare the index against every legal state number. Because the
  // output is a direct function of the registered index, it can only
  // change when the index changes.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < T_WIDTH; i++) begin
      onehot[i] = (sc == CNT_W'(i));
    end
  end

endmodule

// File: rtl/timing_sequencer.sv
// ---------------------------------------------------------------------------
// timing_sequencer
// Instruction timing-state generator. A binary state counter steps through
// T_WIDTH states and is decoded into a one-hot timing vector. Decode logic
// ends an instruction with Clear, stalls it with Hold, or jumps it with
// Load. Retired instructions are counted, and two sticky flags record a
// sequence that wrapped without a Clear and an out-of-range Load target.
//
// Ports:
//   Clock       input         system clock, rising-edge active
//   Reset       input         synchronous active-high reset
//   Clear       input         end of instruction; next state is T0
//   Hold        input         stall; freezes the current state
//   Load        input         forced jump to LoadState
//   LoadState   input  CNT_W  target state index for Load
//   T           output T_WIDTH one-hot timing vector, T[SC] = 1
//   SC          output CNT_W  binary state index
//   FetchPhase  output        high while SC < FETCH_STATES
//   InstrCount  output IC_W   instructions retired via Clear (wraps)
//   Overrun     output        sticky: sequence wrapped without a Clear
//   LoadErr     output        sticky: Load target was out of range
// ---------------------------------------------------------------------------
module timing_sequencer
  import timing_sequencer_pkg::*;
#(
  parameter int T_WIDTH      = DEFAULT_T_WIDTH,
  parameter int CNT_W        = $clog2(T_WIDTH),
  parameter int IC_W         = 16,
  parameter int FETCH_STATES = T_FETCH_H + 1
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Clear,
  input  logic               Hold,
  input  logic               Load,
  input  logic [CNT_W-1:0]   LoadState,
  output logic [T_WIDTH-1:0] T,
  output logic [CNT_W-1:0]   SC,
  output logic               FetchPhase,
  output logic [IC_W-1:0]    InstrCount,
  output logic               Overrun,
  output logic               LoadErr
);

  // The named phases up to T_EXEC0 must all exist, and the one-hot vector
  // is limited to 16 states.
  if (T_WIDTH < T_EXEC0 + 1 || T_WIDTH > 16) begin : g_bad_width
    $error("timing_sequencer: T_WIDTH must be in the range 4..16");
  end

  priority_e        pri;
  logic [CNT_W-1:0] sc_q;
  logic [CNT_W-1:0] sc_d;
  logic [IC_W-1:0]  ic_q;
  logic [IC_W-1:0]  ic_d;
  logic             overrun_q;
  logic             overrun_d;
  logic             load_err_q;
  logic             load_err_d;
  logic [31:0]      load_idx;
  logic             load_in_range;
  logic             at_last_state;

  // The Load target is widened before comparison so that the range check
  // still works when CNT_W can encode more values than there are states.
  assign load_idx      = 32'(LoadState);
  assign load_in_range = load_idx < 32'(T_WIDTH);
  assign at_last_state = (sc_q == CNT_W'(T_WIDTH - 1));

  // Next-state logic. Every target starts as "unchanged" and only the
  // winning action for this edge modifies it. Hold therefore needs no
  // case body: leaving the defaults in place is exactly a freeze. A
  // Clear at the last state goes through the Clear branch and never
  // touches Overrun; only a genuine wrap by increment sets it.
  always_comb begin
    pri        = resolve_priority(Reset, Clear, Load, Hold);
    sc_d       = sc_q;
    ic_d       = ic_q;
    overrun_d  = overrun_q;
    load_err_d = load_err_q;
    case (pri)
      PRI_RESET: begin
        sc_d       = CNT_W'(T_FETCH_L);
        ic_d       = '0;
        overrun_d  = 1'b0;
        load_err_d = 1'b0;
      end
      PRI_CLEAR: begin
        sc_d = CNT_W'(T_FETCH_L);
        ic_d = ic_q + IC_W'(1);
      end
      PRI_LOAD: begin
        if (load_in_range) begin
          sc_d = LoadState;
        end else begin
          load_err_d = 1'b1;
        end
      end
      PRI_HOLD: begin
      end
      PRI_INC: begin
        if (at_last_state) begin
          sc_d      = CNT_W'(T_FETCH_L);
          overrun_d = 1'b1;
        end else begin
          sc_d = sc_q + CNT_W'(1);
        end
      end
      default: begin
      end
    endcase
  end

  // State index register. Reset is checked here as well so the register
  // returns to T0 on any edge where Reset is high.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sc_q <= CNT_W'(T_FETCH_L);
    end else begin
      sc_q <= sc_d;
    end
  end

  // Retired-instruction counter. It wraps silently at 2^IC_W.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ic_q <= '0;
    end else begin
      ic_q <= ic_d;
    end
  end

  // Sticky error flags. Once set, only Reset clears them.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      overrun_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      overrun_q  <= overrun_d;
      load_err_q <= load_err_d;
    end
  end

  sc_onehot_decode #(
    .T_WIDTH (T_WIDTH),
    .CNT_W   (CNT_W)
  ) u_decode (
    .sc     (sc_q),
    .onehot (T)
  );

  // Fetch phase covers the leading FETCH_STATES states of every instruction
  assign FetchPhase = (32'(sc_q) < 32'(FETCH_STATES));
  assign SC         = sc_q;
  assign InstrCount = ic_q;
  assign Overrun    = overrun_q;
  assign LoadErr    = load_err_q;

endmodule

// File: tb/tb_timing_sequencer.sv
// ---------------------------------------------------------------------------
// tb_timing_sequencer
// Self-checking bench for timing_sequencer. Three instances share the same
// stimulus:
//   dutA  T_WIDTH=8,  CNT_W=4, IC_W=16, FETCH_STATES=2
//   dutB  T_WIDTH=8,  CNT_W=4, IC_W=4   (instruction-counter wrap)
//   dutC  T_WIDTH=12, CNT_W=4, FETCH_STATES=3
// CNT_W is 4 on the 8-state instances so that out-of-range Load targets
// such as 9 can be presented at all.
// ---------------------------------------------------------------------------
module tb_timing_sequencer;

  logic        clock;
  logic        reset;
  logic        clear;
  logic        hold;
  logic        load;
  logic [3:0]  loadState;

  logic [7:0]  tA;
  logic [3:0]  scA;
  logic        fetchA;
  logic [15:0] icA;
  logic        overrunA;
  logic        loadErrA;

  logic [7:0]  tB;
  logic [3:0]  scB;
  logic        fetchB;
  logic [3:0]  icB;
  logic        overrunB;
  logic        loadErrB;

  logic [11:0] tC;
  logic [3:0]  scC;
  logic        fetchC;
  logic [15:0] icC;
  logic        overrunC;
  logic        loadErrC;

  int checks   = 0;
  int failures = 0;
  bit started  = 0;

  typedef struct {
    logic       rst;
    logic       clr;
    logic       hld;
    logic       ld;
    logic [3:0] ls;
    int         sc;
    logic [7:0] t;
    logic       ov;
    logic       le;
    int         ic;
  } vec_t;

  vec_t vecs[$];

  timing_sequencer #(
    .T_WIDTH (8), .CNT_W (4), .IC_W (16), .FETCH_STATES (2)
  ) dutA (
    .Clock (clock), .Reset (reset), .Clear (clear), .Hold (hold),
    .Load (load), .LoadState (loadState), .T (tA), .SC (scA),
    .FetchPhase (fetchA), .InstrCount (icA), .Overrun (overrunA),
    .LoadErr (loadErrA)
  );

  timing_sequencer #(
    .T_WIDTH (8), .CNT_W (4), .IC_W (4), .FETCH_STATES (2)
  ) dutB (
    .Clock (clock), .Reset (reset), .Clear (clear), .Hold (hold),
    .Load (load), .LoadState (loadState), .T (tB), .SC (scB),
    .FetchPhase (fetchB), .InstrCount (icB), .Overrun (overrunB),
    .LoadErr (loadErrB)
  );

  timing_sequencer #(
    .T_WIDTH (12), .CNT_W (4), .IC_W (16), .FETCH_STATES (3)
  ) dutC (
    .Clock (clock), .Reset (reset), .Clear (clear), .Hold (hold),
    .Load (load), .LoadState (loadState), .T (tC), .SC (scC),
    .FetchPhase (fetchC), .InstrCount (icC), .Overrun (overrunC),
    .LoadErr (loadErrC)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One-hot property on every falling edge once the first reset is done
  always @(negedge clock) begin
    if (started) begin
      checks += 3;
      assert ($onehot(tA)) else begin
        failures++;
        $display("[TB] FAIL onehot_A actual=%h required=one bit set", tA);
      end
      assert ($onehot(tB)) else begin
        failures++;
        $display("[TB] FAIL onehot_B actual=%h required=one bit set", tB);
      end
      assert ($onehot(tC)) else begin
        failures++;
        $display("[TB] FAIL onehot_C actual=%h required=one bit set", tC);
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic c, input logic h,
                               input logic l, input logic [3:0] ls);
    reset     = r;
    clear     = c;
    hold      = h;
    load      = l;
    loadState = ls;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual,
                             input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic add(input logic r, input logic c, input logic h,
                     input logic l, input logic [3:0] ls, input int sc,
                     input logic [7:0] t, input logic ov, input logic le,
                     input int ic);
    vec_t v;
    v.rst = r; v.clr = c; v.hld = h; v.ld = l; v.ls = ls;
    v.sc = sc; v.t = t; v.ov = ov; v.le = le; v.ic = ic;
    vecs.push_back(v);
  endtask

  initial begin
    applyStimulus(1, 0, 0, 0, 0);

    // Reset then free-run through a full wrap
    add(1, 0, 0, 0, 0, 0, 8'h01, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 8'h02, 0, 0, 0);
    add(0, 0, 0, 0, 0, 2, 8'h04, 0, 0, 0);
    add(0, 0, 0, 0, 0, 3, 8'h08, 0, 0, 0);
    add(0, 0, 0, 0, 0, 4, 8'h10, 0, 0, 0);
    add(0, 0, 0, 0, 0, 5, 8'h20, 0, 0, 0);
    add(0, 0, 0, 0, 0, 6, 8'h40, 0, 0, 0);
    add(0, 0, 0, 0, 0, 7, 8'h80, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 8'h01, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 8'h02, 1, 0, 0);

    // Reset, then three instructions each cleared at SC=4
    add(1, 0, 0, 0, 0, 0, 8'h01, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      add(0, 0, 0, 0, 0, 1, 8'h02, 0, 0, k - 1);
      add(0, 0, 0, 0, 0, 2, 8'h04, 0, 0, k - 1);
      add(0, 0, 0, 0, 0, 3, 8'h08, 0, 0, k - 1);
      add(0, 0, 0, 0, 0, 4, 8'h10, 0, 0, k - 1);
      add(0, 1, 0, 0, 0, 0, 8'h01, 0, 0, k);
    end

    // Hold for five edges at SC=3, then resume with an increment
    add(0, 0, 0, 0, 0, 1, 8'h02, 0, 0, 3);
    add(0, 0, 0, 0, 0, 2, 8'h04, 0, 0, 3);
    add(0, 0, 0, 0, 0, 3, 8'h08, 0, 0, 3);
    for (int k = 0; k < 5; k++) begin
      add(0, 0, 1, 0, 0, 3, 8'h08, 0, 0, 3);
    end
    add(0, 0, 0, 0, 0, 4, 8'h10, 0, 0, 3);

    // Load cases and combined requests
    add(0, 1, 0, 0, 0, 0, 8'h01, 0, 0, 4);
    add(0, 0, 0, 0, 0, 1, 8'h02, 0, 0, 4);
    add(0, 0, 0, 0, 0, 2, 8'h04, 0, 0, 4);
    add(0, 0, 0, 1, 6, 6, 8'h40, 0, 0, 4);
    add(0, 0, 0, 1, 9, 6, 8'h40, 0, 1, 4);
    add(0, 1, 1, 1, 5, 0, 8'h01, 0, 1, 5);
    add(0, 0, 1, 1, 3, 3, 8'h08, 0, 1, 5);
    add(0, 0, 0, 1, 7, 7, 8'h80, 0, 1, 5);
    add(0, 1, 1, 0, 0, 0, 8'h01, 0, 1, 6);
    add(0, 0, 0, 1, 7, 7, 8'h80, 0, 1, 6);
    add(0, 0, 0, 0, 0, 0, 8'h01, 1, 1, 6);
    add(0, 0, 1, 1, 12, 0, 8'h01, 1, 1, 6);
    add(1, 1, 1, 1, 5, 0, 8'h01, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].clr, vecs[i].hld, vecs[i].ld,
                    vecs[i].ls);
      step();
      started = 1;
      checkOutput($sformatf("v%0d_sc", i), int'(scA), vecs[i].sc);
      checkOutput($sformatf("v%0d_t", i), int'(tA), int'(vecs[i].t));
      checkOutput($sformatf("v%0d_fetch", i), int'(fetchA),
                  (vecs[i].sc < 2) ? 1 : 0);
      checkOutput($sformatf("v%0d_overrun", i), int'(overrunA),
                  int'(vecs[i].ov));
      checkOutput($sformatf("v%0d_loaderr", i), int'(loadErrA),
                  int'(vecs[i].le));
      checkOutput($sformatf("v%0d_icA", i), int'(icA), vecs[i].ic);
      checkOutput($sformatf("v%0d_icB", i), int'(icB), vecs[i].ic % 16);
    end

    // Seventeen Clears: the 4-bit counter wraps through zero to one
    for (int k = 1; k <= 17; k++) begin
      applyStimulus(0, 1, 0, 0, 0);
      step();
      if (k == 16) begin
        checkOutput("ic_wrap16_B", int'(icB), 0);
      end
    end
    checkOutput("ic17_A", int'(icA), 17);
    checkOutput("ic17_B", int'(icB), 1);
    checkOutput("ic17_sc", int'(scA), 0);

    // Set LoadErr, run to SC=5, then Reset together with Hold
    applyStimulus(0, 0, 0, 1, 15);
    step();
    checkOutput("ld15_loaderr", int'(loadErrA), 1);
    checkOutput("ld15_sc", int'(scA), 0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 0, 0, 0, 0);
      step();
    end
    checkOutput("pre_reset_sc", int'(scA), 5);
    applyStimulus(1, 0, 1, 0, 0);
    step();
    checkOutput("rsthold_sc", int'(scA), 0);
    checkOutput("rsthold_t", int'(tA), 1);
    checkOutput("rsthold_fetch", int'(fetchA), 1);
    checkOutput("rsthold_icA", int'(icA), 0);
    checkOutput("rsthold_icB", int'(icB), 0);
    checkOutput("rsthold_overrun", int'(overrunA), 0);
    checkOutput("rsthold_loaderr", int'(loadErrA), 0);
    checkOutput("rsthold_scC", int'(scC), 0);

    // Twelve-state instance free-runs two full sequences
    applyStimulus(0, 0, 0, 0, 0);
    for (int i = 0; i < 26; i++) begin
      int s;
      s = i % 12;
      checkOutput($sformatf("c%0d_sc", i), int'(scC), s);
      checkOutput($sformatf("c%0d_t", i), int'(tC), 1 << s);
      checkOutput($sformatf("c%0d_fetch", i), int'(fetchC), (s < 3) ? 1 : 0);
      step();
    end
    checkOutput("c_overrun", int'(overrunC), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
